// File: rtl/instruction_loader.sv
// Assembles a UART byte stream into instruction words, loads them, and sequences run/halt.
// Optional single-step support: define INSTRUCTION_LOADER_STEP_EN.
module instruction_loader #(
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int PC_LENGTH = 32,
    parameter int MEM_DEPTH = 64,
    parameter logic [INSTRUCTION_LENGTH-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [7:0] CMD_LOAD = 8'h4C,
    parameter logic [7:0] CMD_RUN = 8'h52
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done,
    input  logic                          halt_detected,
    output logic                          wr_memory_instruction_enable,
    output logic [INSTRUCTION_LENGTH-1:0] instruction_to_write,
    output logic [PC_LENGTH-1:0]          address_to_write,
    output logic                          mips_enable,
    output logic                          load_done,
    output logic                          load_error,
    output logic [31:0]                   word_count
`ifdef INSTRUCTION_LOADER_STEP_EN
    ,
    output logic [31:0]                   step_count
`endif
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
    localparam logic [7:0] CMD_STEP = 8'h53;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        READY,
        RUN,
        ERROR
    } state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    byte_idx_q, byte_idx_d;
    logic [INSTRUCTION_LENGTH-1:0] asm_q, asm_d;
    logic [PC_LENGTH-1:0]          addr_q, addr_d;
    logic [31:0]                   word_count_q, word_count_d;
    logic                          load_done_q, load_done_d;
`ifdef INSTRUCTION_LOADER_STEP_EN
    logic                          step_q, step_d;
    logic [31:0]                   step_count_q, step_count_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
`ifdef INSTRUCTION_LOADER_STEP_EN
            step_q       <= 1'b0;
            step_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
`ifdef INSTRUCTION_LOADER_STEP_EN
            step_q       <= step_d;
            step_count_q <= step_count_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
`ifdef INSTRUCTION_LOADER_STEP_EN
        step_d       = 1'b0;
        step_count_d = step_count_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_done && rx_data == CMD_LOAD) begin
                    state_d      = RECV;
                    addr_d       = '0;
                    word_count_d = '0;
                    byte_idx_d   = '0;
                    load_done_d  = 1'b0;
                end
            end
            RECV: begin
                if (rx_done) begin
                    asm_d      = {asm_q[INSTRUCTION_LENGTH-9:0], rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d       = addr_q + PC_LENGTH'(4);
                word_count_d = word_count_q + 32'd1;
                if (asm_q == HALT_WORD) begin
                    state_d     = READY;
                    load_done_d = 1'b1;
                end else if (word_count_q + 32'd1 == DEPTH_W) begin
                    state_d = ERROR;
                end else begin
                    state_d = RECV;
                    // A byte landing during the write opens the next word.
                    if (rx_done) begin
                        asm_d      = {asm_q[INSTRUCTION_LENGTH-9:0], rx_data};
                        byte_idx_d = 2'd1;
                    end
                end
            end
            READY: begin
                if (rx_done && rx_data == CMD_LOAD) begin
                    state_d      = RECV;
                    addr_d       = '0;
                    word_count_d = '0;
                    byte_idx_d   = '0;
                    load_done_d  = 1'b0;
                end else if (rx_done && rx_data == CMD_RUN) begin
                    state_d = RUN;
`ifdef INSTRUCTION_LOADER_STEP_EN
                end else if (rx_done && rx_data == CMD_STEP) begin
                    step_d       = 1'b1;
                    step_count_d = step_count_q + 32'd1;
`endif
                end
            end
            RUN: begin
                if (halt_detected) begin
                    state_d = READY;
                end
            end
            ERROR: begin
                if (rx_done && rx_data == CMD_LOAD) begin
                    state_d      = RECV;
                    addr_d       = '0;
                    word_count_d = '0;
                    byte_idx_d   = '0;
                    load_done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_memory_instruction_enable = (state_q == WRITE);
    assign instruction_to_write = asm_q;
    assign address_to_write = addr_q;
    assign load_done = load_done_q;
    assign load_error = (state_q == ERROR);
    assign word_count = word_count_q;
`ifdef INSTRUCTION_LOADER_STEP_EN
    assign mips_enable = (state_q == RUN) | step_q;
    assign step_count = step_count_q;
`else
    assign mips_enable = (state_q == RUN);
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: per-cycle vector table plus reset sequences.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        halt_detected;
    logic        wr_en;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        mips_enable;
    logic        load_done;
    logic        load_error;
    logic [31:0] word_count;
`ifdef INSTRUCTION_LOADER_STEP_EN
    logic [31:0] step_count;
    localparam logic STEP = 1'b1;
`else
    localparam logic STEP = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instruction_loader #(.MEM_DEPTH(4)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .rx_data                      (rx_data),
        .rx_done                      (rx_done),
        .halt_detected                (halt_detected),
        .wr_memory_instruction_enable (wr_en),
        .instruction_to_write         (instr),
        .address_to_write             (addr),
        .mips_enable                  (mips_enable),
        .load_done                    (load_done),
        .load_error                   (load_error),
        .word_count                   (word_count)
`ifdef INSTRUCTION_LOADER_STEP_EN
        ,
        .step_count                   (step_count)
`endif
    );

    // One row per clock: expected outputs during the cycle, inputs applied in it.
    typedef struct {
        logic        rxd;
        logic [7:0]  data;
        logic        halt;
        logic        wr;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        mips;
        logic        done;
        logic        err;
        logic [31:0] wc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rxd, logic [7:0] data, logic halt,
                                logic wr, logic [31:0] ei, logic [31:0] ea,
                                logic mips, logic done, logic err,
                                logic [31:0] wc);
        vec_t v;
        v.rxd = rxd; v.data = data; v.halt = halt;
        v.wr = wr; v.instr = ei; v.addr = ea;
        v.mips = mips; v.done = done; v.err = err; v.wc = wc;
        tbl.push_back(v);
    endfunction

    // Plain byte while outputs are expected idle-ish (no write, no run).
    function automatic void byte_row(logic [7:0] b, logic done,
                                     logic err, logic [31:0] wc);
        add(1'b1, b, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, done, err, wc);
    endfunction

    task automatic check_zero(string name);
        tests++;
        if (wr_en !== 1'b0 || instr !== 32'h0 || addr !== 32'h0 ||
            mips_enable !== 1'b0 || load_done !== 1'b0 ||
            load_error !== 1'b0 || word_count !== 32'h0) begin
            fails++;
            $display("FAIL %s: wr=%b instr=%h addr=%h mips=%b done=%b err=%b wc=%0d, all must be 0",
                     name, wr_en, instr, addr, mips_enable, load_done,
                     load_error, word_count);
        end
    endtask

    task automatic send(logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        halt_detected = 1'b0;

        // reset-abort load, then load 00200820 + HALT
        byte_row(8'h4C, 0, 0, 0);
        byte_row(8'h00, 0, 0, 0);
        byte_row(8'h20, 0, 0, 0);
        byte_row(8'h08, 0, 0, 0);
        byte_row(8'h20, 0, 0, 0);
        add(0, 8'h00, 0, 1, 32'h0020_0820, 32'h0, 0, 0, 0, 0);
        byte_row(8'hFF, 0, 0, 1);
        byte_row(8'hFF, 0, 0, 1);
        byte_row(8'hFF, 0, 0, 1);
        byte_row(8'hFF, 0, 0, 1);
        add(0, 8'h00, 0, 1, 32'hFFFF_FFFF, 32'h4, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 1, 0, 2);
        byte_row(8'h52, 1, 0, 2);
        // run, ignore rx, then halt
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, 1, 1, 0, 2);
        add(1, 8'h4C, 0, 0, 32'h0, 32'h0, 1, 1, 0, 2);
        add(0, 8'h00, 1, 0, 32'h0, 32'h0, 1, 1, 0, 2);
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 1, 0, 2);
        // reload with back-to-back bytes
        byte_row(8'h4C, 1, 0, 2);
        byte_row(8'h11, 0, 0, 0);
        byte_row(8'h22, 0, 0, 0);
        byte_row(8'h33, 0, 0, 0);
        byte_row(8'h44, 0, 0, 0);
        add(1, 8'h55, 0, 1, 32'h1122_3344, 32'h0, 0, 0, 0, 0);
        byte_row(8'h66, 0, 0, 1);
        byte_row(8'h77, 0, 0, 1);
        byte_row(8'h88, 0, 0, 1);
        add(0, 8'h00, 0, 1, 32'h5566_7788, 32'h4, 0, 0, 0, 1);
        // two more words overflow MEM_DEPTH = 4
        byte_row(8'hAA, 0, 0, 2);
        byte_row(8'hBB, 0, 0, 2);
        byte_row(8'hCC, 0, 0, 2);
        byte_row(8'hDD, 0, 0, 2);
        add(0, 8'h00, 0, 1, 32'hAABB_CCDD, 32'h8, 0, 0, 0, 2);
        byte_row(8'h01, 0, 0, 3);
        byte_row(8'h02, 0, 0, 3);
        byte_row(8'h03, 0, 0, 3);
        byte_row(8'h04, 0, 0, 3);
        add(0, 8'h00, 0, 1, 32'h0102_0304, 32'hC, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 0, 1, 4);
        byte_row(8'h52, 0, 1, 4);
        byte_row(8'h4C, 0, 1, 4);
        // error cleared, load a lone HALT, then step
        byte_row(8'hFF, 0, 0, 0);
        byte_row(8'hFF, 0, 0, 0);
        byte_row(8'hFF, 0, 0, 0);
        byte_row(8'hFF, 0, 0, 0);
        add(0, 8'h00, 0, 1, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0);
        byte_row(8'h53, 1, 0, 1);
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, STEP, 1, 0, 1);
        add(0, 8'h00, 1, 0, 32'h0, 32'h0, 0, 1, 0, 1);
        byte_row(8'h53, 1, 0, 1);
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, STEP, 1, 0, 1);
        byte_row(8'h53, 1, 0, 1);
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, STEP, 1, 0, 1);
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 1, 0, 1);

        // reset state
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b1;

        // abort a partial load with reset
        send(8'h4C);
        send(8'h12);
        send(8'h34);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("reset_mid_recv");
        @(negedge clk);
        check_zero("reset_held");
        reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            tests++;
            if (wr_en !== tbl[i].wr || mips_enable !== tbl[i].mips ||
                load_done !== tbl[i].done || load_error !== tbl[i].err ||
                word_count !== tbl[i].wc ||
                (tbl[i].wr && (instr !== tbl[i].instr ||
                               addr !== tbl[i].addr))) begin
                fails++;
                $display("FAIL row%0d: got wr=%b instr=%h addr=%h mips=%b done=%b err=%b wc=%0d; want wr=%b instr=%h addr=%h mips=%b done=%b err=%b wc=%0d",
                         i, wr_en, instr, addr, mips_enable, load_done,
                         load_error, word_count, tbl[i].wr, tbl[i].instr,
                         tbl[i].addr, tbl[i].mips, tbl[i].done,
                         tbl[i].err, tbl[i].wc);
            end
            rx_done = tbl[i].rxd;
            rx_data = tbl[i].data;
            halt_detected = tbl[i].halt;
        end

`ifdef INSTRUCTION_LOADER_STEP_EN
        @(negedge clk);
        tests++;
        if (step_count !== 32'd3) begin
            fails++;
            $display("FAIL step_count: got %0d want 3", step_count);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Upstream feeder of the instruction fetch stage.
- Receives a program byte-stream from the UART receiver and assembles 32-bit instructions from it.
- Writes each instruction into instruction memory through the fetch stage's write port (write enable, data, address), then hands control to the pipeline by driving mips_enable.
- Owns the load/run sequencing of the whole processor.

Parameters:
- INSTRUCTION_LENGTH, 32, instruction word width (fixed at 4 bytes).
- PC_LENGTH, 32, address width.
- MEM_DEPTH, 64, instruction memory capacity in words.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker.
- CMD_LOAD, 8'h4C, command byte that starts a load.
- CMD_RUN, 8'h52, command byte that starts continuous run.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the UART receiver.
- rx_done  in  1  one-cycle strobe; rx_data is valid in this cycle.
- halt_detected  in  1  pipeline retired the HALT instruction.
- wr_memory_instruction_enable  out  1  instruction memory write strobe.
- instruction_to_write  out  32  word being written.
- address_to_write  out  32  byte address of the word being written.
- mips_enable  out  1  pipeline/PC enable.
- load_done  out  1  program resident in memory.
- load_error  out  1  program exceeded MEM_DEPTH.
- word_count  out  32  number of words written in the last load.

Behaviour:

Reset (reset = 0, asynchronous):
- Every output is 0.
- State returns to IDLE and the byte index is cleared.
- Reset asserted mid-load or mid-run aborts immediately; no partial write completes.

States: IDLE, RECV, WRITE, READY, RUN, ERROR.

IDLE:
- rx_done with rx_data == CMD_LOAD → RECV; clear address, word_count and byte index.
- Any other byte is ignored.

RECV:
- Each rx_done shifts rx_data into an assembly register, MSB first: the first byte lands in [31:24].
- When the 4th byte arrives, go to WRITE on the next edge.

WRITE (exactly one cycle):
- wr_memory_instruction_enable = 1, with instruction_to_write and address_to_write stable for the same cycle.
- Next edge: address_to_write += 4, word_count += 1.
- If the written word == HALT_WORD → READY, load_done = 1. The HALT word itself is stored.
- Else if word_count + 1 == MEM_DEPTH → ERROR.
- Else → RECV.

Timing and framing:
- Latency from the 4th rx_done to the write strobe is 1 cycle.
- An rx_done arriving during WRITE is captured as byte 0 of the next word; no byte is lost.

READY:
- rx_done with CMD_RUN → RUN: mips_enable = 1 from the next cycle.
- rx_done with CMD_LOAD → reload. Go to RECV, clear load_done, word_count and address.

RUN:
- mips_enable held at 1.
- wr_memory_instruction_enable is guaranteed 0 throughout.
- halt_detected = 1 → mips_enable = 0 on the next edge, go to READY, load_done stays 1.
- rx_data is ignored while in RUN.

ERROR:
- load_error = 1, mips_enable = 0.
- Only CMD_LOAD leaves this state: go to RECV and clear load_error.

Invariants:
- mips_enable and wr_memory_instruction_enable are never 1 in the same cycle.
- address_to_write is always a multiple of 4. Wrap is impossible because of the MEM_DEPTH guard.

Optional Feature:
- Macro: INSTRUCTION_LOADER_STEP_EN.
- When defined:
  - In READY, the byte 8'h53 produces a single-cycle mips_enable pulse: exactly one clock of 1, then back to 0. The state stays READY.
  - halt_detected during a step is accepted, and further steps remain legal.
  - A step_count output (32 bits, reset 0) increments once per pulse.
- When not defined:
  - 8'h53 is ignored like any unknown byte.
  - The step_count port does not exist.

Test Plan:
- Reset mid-RECV: send 4C, 12, 34 then pulse reset low → all outputs 0, state IDLE. A following 4C plus 4 bytes writes at address 0.
- Normal load: 4C, then 00 20 08 20, then FF FF FF FF → writes 0x00200820 @0x0 and 0xFFFFFFFF @0x4, each as a single 1-cycle strobe. Then load_done = 1, word_count = 2, mips_enable = 0.
- Run to halt: after the normal load, send 52 → mips_enable = 1 the next cycle. Pulse halt_detected → mips_enable = 0 one edge later, load_done = 1.
- Overflow: MEM_DEPTH = 4, send 4C plus 4 non-HALT words → 4 writes at 0x0 to 0xC, then load_error = 1. A following 4C clears load_error.
- Back-to-back bytes: rx_done every cycle for 8 bytes → two writes with no dropped byte; the 5th byte lands in [31:24] of the second word.
- With INSTRUCTION_LOADER_STEP_EN: in READY send 53 three times → three 1-cycle mips_enable pulses, step_count = 3. Without the macro → mips_enable stays 0.
